// File: rtl/usb_sync_tx.sv
// K/J line transmitter: SYNC, NRZI data LSB first, then EOP (SE0 SE0 J).
// Define USB_TX_STUFF_EN to insert a toggle after six consecutive ones.
module usb_sync_tx #(
    parameter int unsigned BIT_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       k,
    output logic       j,
    output logic       tx_en,
    output logic       busy,
    output logic       done,
    output logic       tx_err
);
    localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
`ifdef USB_TX_STUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [2:0]         ones_q, ones_d;
    logic [7:0]         shift_q, shift_d;
    logic               last_q, last_d;
    logic               stuff_q, stuff_d;
    logic               end_q, end_d;
    logic               k_q, k_d, j_q, j_d;
    logic               tx_en_q, tx_en_d;
    logic               busy_q, busy_d;
    logic               tx_ready_q, tx_ready_d;
    logic               tx_err_q, tx_err_d;
    logic               done_q, done_d;

    logic               tick;
    logic               stuff_now;
    logic               bit_vld, bit_val, fin, go_eop;
    logic [2:0]         ones_base;

    assign tick      = (div_q == DIV_W'(BIT_DIV - 1));
    assign stuff_now = STUFF_EN && (ones_q == 3'd6);

    // Line state always reflects the symbol currently being held; each tick picks the next one
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        shift_d    = shift_q;
        last_d     = last_q;
        stuff_d    = stuff_q;
        end_d      = end_q;
        k_d        = k_q;
        j_d        = j_q;
        tx_en_d    = tx_en_q;
        tx_ready_d = 1'b0;
        tx_err_d   = 1'b0;
        done_d     = 1'b0;
        bit_vld    = 1'b0;
        bit_val    = 1'b0;
        fin        = 1'b0;
        go_eop     = 1'b0;
        ones_base  = ones_q;

        if (state_q != IDLE) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                k_d     = 1'b0;
                j_d     = 1'b1;
                tx_en_d = 1'b0;
                if (tx_start && tx_valid) begin
                    state_d    = SYNC;
                    shift_d    = tx_data;
                    last_d     = tx_last;
                    tx_ready_d = 1'b1;
                    tx_en_d    = 1'b1;
                    div_d      = '0;
                    cnt_d      = '0;
                    ones_d     = '0;
                    stuff_d    = 1'b0;
                    end_d      = 1'b0;
                    k_d        = 1'b1;
                    j_d        = 1'b0;
                end
            end
            SYNC: begin
                if (tick) begin
                    bit_vld = 1'b1;
                    if (cnt_q == 3'd7) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_val   = shift_q[0];
                        ones_base = 3'd1;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        bit_val = (cnt_q == 3'd6);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (stuff_q) begin
                        stuff_d = 1'b0;
                        if (end_q) begin
                            go_eop = 1'b1;
                        end else begin
                            bit_vld = 1'b1;
                            bit_val = shift_q[0];
                        end
                    end else begin
                        if (cnt_q == 3'd7) begin
                            cnt_d = '0;
                            if (last_q) begin
                                fin = 1'b1;
                            end else if (tx_valid) begin
                                shift_d    = tx_data;
                                last_d     = tx_last;
                                tx_ready_d = 1'b1;
                            end else begin
                                tx_err_d = 1'b1;
                                fin      = 1'b1;
                            end
                        end else begin
                            cnt_d   = cnt_q + 3'd1;
                            shift_d = shift_q >> 1;
                        end
                        // A pending stuff toggle goes out before the next data bit or EOP
                        if (stuff_now) begin
                            stuff_d = 1'b1;
                            end_d   = fin;
                            bit_vld = 1'b1;
                            bit_val = 1'b0;
                        end else if (fin) begin
                            go_eop = 1'b1;
                        end else begin
                            bit_vld = 1'b1;
                            bit_val = shift_d[0];
                        end
                    end
                end
            end
            EOP: begin
                if (tick) begin
                    if (cnt_q == 3'd2) begin
                        state_d = IDLE;
                        tx_en_d = 1'b0;
                        done_d  = 1'b1;
                        k_d     = 1'b0;
                        j_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd1) begin
                            k_d = 1'b0;
                            j_d = 1'b1;
                        end
                    end
                end
            end
        endcase

        // NRZI: a zero toggles the line, a one holds it
        if (bit_vld) begin
            if (!bit_val) begin
                k_d = ~k_q;
                j_d = ~j_q;
            end
            ones_d = bit_val ? ((ones_base == 3'd7) ? 3'd7 : ones_base + 3'd1) : 3'd0;
        end
        if (go_eop) begin
            state_d = EOP;
            cnt_d   = '0;
            k_d     = 1'b0;
            j_d     = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            ones_q     <= '0;
            shift_q    <= '0;
            last_q     <= 1'b0;
            stuff_q    <= 1'b0;
            end_q      <= 1'b0;
            k_q        <= 1'b0;
            j_q        <= 1'b1;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_err_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            ones_q     <= ones_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            stuff_q    <= stuff_d;
            end_q      <= end_d;
            k_q        <= k_d;
            j_q        <= j_d;
            tx_en_q    <= tx_en_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            tx_err_q   <= tx_err_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign k        = k_q;
    assign j        = j_q;
    assign tx_en    = tx_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_err   = tx_err_q;
endmodule

// File: tb/tb_usb_sync_tx.sv
// Bench for usb_sync_tx: two instances (BIT_DIV 1 and 4), random packets
// compared cycle by cycle against a bit-stream level model of the line.
module tb_usb_sync_tx;
`ifdef USB_TX_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif
    localparam logic [1:0] SYM_K   = 2'b10;
    localparam logic [1:0] SYM_J   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;
    localparam logic [6:0] IDLE_V  = 7'b0010000;

    logic       clk;
    logic [1:0] rst, tx_start, tx_valid, tx_last;
    logic [7:0] tx_data [2];
    logic [1:0] tx_ready, k, j, tx_en, busy, done, tx_err;

    int n_checks = 0;
    int n_fail   = 0;
    int pkt_no   = 0;

    logic [7:0] pkt_q[$];
    logic [1:0] exp_sym[$];
    int         ready_idx[$];
    int         err_idx;

    usb_sync_tx #(.BIT_DIV(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .tx_valid(tx_valid[0]), .tx_last(tx_last[0]), .tx_ready(tx_ready[0]),
        .k(k[0]), .j(j[0]), .tx_en(tx_en[0]), .busy(busy[0]), .done(done[0]),
        .tx_err(tx_err[0])
    );

    usb_sync_tx #(.BIT_DIV(4)) u_dut1 (
        .clk(clk), .rst(rst[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .tx_valid(tx_valid[1]), .tx_last(tx_last[1]), .tx_ready(tx_ready[1]),
        .k(k[1]), .j(j[1]), .tx_en(tx_en[1]), .busy(busy[1]), .done(done[1]),
        .tx_err(tx_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bd(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [6:0] obs(input int d);
        return {tx_en[d], k[d], j[d], busy[d], tx_ready[d], tx_err[d], done[d]};
    endfunction

    // Bit-level view: SYNC byte, data bits with optional stuffing, NRZI from J, then EOP
    task automatic build_model(input bit underrun);
        bit lvl;
        int ones;
        int n;
        bit b;
        exp_sym.delete();
        ready_idx.delete();
        ready_idx.push_back(0);
        err_idx = -1;
        lvl  = 1'b1;
        n    = pkt_q.size();
        for (int i = 0; i < 8; i++) begin
            b = (i == 7);
            if (!b) lvl = ~lvl;
            exp_sym.push_back(lvl ? SYM_J : SYM_K);
        end
        ones = 1;
        for (int i = 0; i < n; i++) begin
            for (int bn = 0; bn < 8; bn++) begin
                b = pkt_q[i][bn];
                if (!b) lvl = ~lvl;
                exp_sym.push_back(lvl ? SYM_J : SYM_K);
                ones = b ? ones + 1 : 0;
                if (bn == 7) begin
                    if (i < n - 1) ready_idx.push_back(exp_sym.size());
                    else if (underrun) err_idx = exp_sym.size();
                end
                if (STUFF && ones == 6) begin
                    lvl = ~lvl;
                    exp_sym.push_back(lvl ? SYM_J : SYM_K);
                    ones = 0;
                end
            end
        end
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_SE0);
        exp_sym.push_back(SYM_J);
    endtask

    function automatic logic [6:0] exp_vec(input int d, input int cyc, input int total);
        int s;
        bit ph0, rdy, err;
        if (cyc == total) return 7'b0010001;
        if (cyc > total) return IDLE_V;
        s   = cyc / bd(d);
        ph0 = (cyc % bd(d)) == 0;
        rdy = 1'b0;
        foreach (ready_idx[i]) if (ready_idx[i] == s) rdy = ph0;
        err = ph0 && (s == err_idx);
        return {1'b1, exp_sym[s], 1'b1, rdy, err, 1'b0};
    endfunction

    // Sends pkt_q; abort_at >= 0 pulses rst at that cycle and then expects a silent idle line
    task automatic run_packet(input int d, input bit underrun, input int abort_at);
        int n, total, bi;
        n  = pkt_q.size();
        bi = 0;
        build_model(underrun);
        total = exp_sym.size() * bd(d);
        pkt_no++;
        tx_start[d] = 1'b1;
        tx_valid[d] = 1'b1;
        tx_data[d]  = pkt_q[0];
        tx_last[d]  = (n == 1) && !underrun;
        for (int cyc = 0; cyc <= total + 1; cyc++) begin
            @(negedge clk);
            check($sformatf("d%0d p%0d c%0d", d, pkt_no, cyc), 32'(obs(d)), 32'(exp_vec(d, cyc, total)));
            tx_start[d] = (cyc < total) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (tx_ready[d]) begin
                bi++;
                if (bi < n) begin
                    tx_data[d] = pkt_q[bi];
                    tx_last[d] = (bi == n - 1) && !underrun;
                end else begin
                    tx_valid[d] = 1'b0;
                end
            end
            if (!tx_valid[d]) begin
                tx_data[d] = 8'($urandom);
                tx_last[d] = 1'($urandom_range(0, 1));
            end
            if (cyc == abort_at) begin
                rst[d]      = 1'b1;
                tx_start[d] = 1'b0;
                tx_valid[d] = 1'b0;
                @(negedge clk);
                check($sformatf("d%0d rst_mid", d), 32'(obs(d)), 32'(IDLE_V));
                rst[d] = 1'b0;
                for (int c = 0; c < 24; c++) begin
                    @(negedge clk);
                    check($sformatf("d%0d post_rst c%0d", d, c), 32'(obs(d)), 32'(IDLE_V));
                end
                break;
            end
        end
        tx_start[d] = 1'b0;
        tx_valid[d] = 1'b0;
        tx_last[d]  = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_packet(input int d);
        int n;
        pkt_q.delete();
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++)
            pkt_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
        run_packet(d, $urandom_range(0, 4) == 0, -1);
    endtask

    initial begin
        rst        = 2'b11;
        tx_start   = '0;
        tx_valid   = '0;
        tx_last    = '0;
        tx_data[0] = '0;
        tx_data[1] = '0;
        repeat (3) @(negedge clk);
        check("rst0", 32'(obs(0)), 32'(IDLE_V));
        check("rst1", 32'(obs(1)), 32'(IDLE_V));
        rst = 2'b00;

        // Start without valid must be ignored
        tx_start = 2'b11;
        tx_data[0] = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check("nostart0", 32'(obs(0)), 32'(IDLE_V));
            check("nostart1", 32'(obs(1)), 32'(IDLE_V));
        end
        tx_start = 2'b00;
        @(negedge clk);

        pkt_q.delete(); pkt_q.push_back(8'h00);
        run_packet(0, 1'b0, -1);
        pkt_q.delete(); pkt_q.push_back(8'hFF);
        run_packet(0, 1'b0, -1);
        pkt_q.delete(); pkt_q.push_back(8'hA5); pkt_q.push_back(8'h3C);
        run_packet(0, 1'b0, -1);
        pkt_q.delete(); pkt_q.push_back(8'h12);
        run_packet(0, 1'b1, -1);
        pkt_q.delete(); pkt_q.push_back(8'hFF); pkt_q.push_back(8'hFF); pkt_q.push_back(8'h7E);
        run_packet(0, 1'b0, -1);
        repeat (25) rand_packet(0);

        pkt_q.delete(); pkt_q.push_back(8'hC3); pkt_q.push_back(8'hFF);
        run_packet(1, 1'b0, -1);
        pkt_q.delete(); pkt_q.push_back(8'h81);
        run_packet(1, 1'b0, 9);
        repeat (5) rand_packet(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_sync_tx.md
Name: usb_sync_tx

Overview:
- Transmit side of the full-speed-style K/J line protocol whose receiver detects the KJKJKJKK sync pattern.
- Takes bytes over a valid/ready/last handshake and drives the line as k/j symbols: SYNC, NRZI-encoded data (LSB first), then EOP.
- Sits between the packet assembler and the line driver; its output feeds the sync detector directly in loopback benches.

Parameters:
- BIT_DIV, 1, clk cycles per line symbol (>=1); symbol tick when divider counter = BIT_DIV-1.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- tx_start  input  1  start request; honoured only in IDLE with tx_valid=1
- tx_data  input  8  byte to send, LSB first
- tx_valid  input  1  tx_data/tx_last valid
- tx_last  input  1  current byte is the final byte of the packet
- tx_ready  output  1  one-cycle pulse: byte latched this cycle
- k  output  1  line drives K
- j  output  1  line drives J (k=j=0 is SE0)
- tx_en  output  1  line driver enable
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the EOP J symbol completes
- tx_err  output  1  one-cycle pulse on underrun

Behaviour:
- Reset: k=0, j=1, tx_en=0, tx_ready=0, busy=0, done=0, tx_err=0; FSM to IDLE; divider, shift register and ones counter cleared.
- IDLE: tx_en=0, line J (k=0, j=1). tx_start with tx_valid=1 latches tx_data/tx_last, pulses tx_ready, and enters SYNC. tx_start without tx_valid is ignored. tx_start outside IDLE is always ignored.
- Timing: tx_en and the first symbol appear on the cycle after acceptance. Each symbol is held for exactly BIT_DIV cycles. All transitions occur on symbol ticks.
- NRZI: bit 0 toggles the line (J<->K); bit 1 holds the line. The line level is J at the start of SYNC.
- SYNC: sends byte 0x80 LSB first, 8 symbols: K J K J K J K K. The ones counter is set to 1 on exit.
- DATA: shifts out 8 bits of the latched byte.
  - Each 1 increments the ones counter; each 0 clears it.
  - At the tick ending the 8th bit: if the byte's tx_last=0 and tx_valid=1, latch the next byte and pulse tx_ready; continue with no gap.
  - If tx_last=1, enter EOP.
  - If tx_last=0 and tx_valid=0 (underrun), pulse tx_err and enter EOP.
- Stuffing: see Optional Feature.
- EOP: SE0 (k=0, j=0) for 2 symbols, then J for 1 symbol. Then tx_en=0, done pulses once, return to IDLE.
- Exclusivity: k and j are never both 1. Outputs are registered.
- Reset mid-operation: next cycle shows the reset values. No EOP, no done, no tx_err.
- tx_data is sampled only on a tx_ready cycle; changes at any other time have no effect.

Optional Feature:
- USB_TX_STUFF_EN defined:
  - After the ones counter reaches 6, the next symbol is a stuff bit (a line toggle) and the counter is cleared; the current data bit is deferred one symbol.
  - A stuff bit owed after the last data bit is sent before EOP.
  - tx_ready timing shifts by inserted symbols.
- USB_TX_STUFF_EN undefined:
  - No stuff symbols are inserted; the ones counter is unused.
  - Packet symbol count is always 8 + 8*N + 3.

Test Plan:
- BIT_DIV=1, byte 0x00 tx_last=1 -> symbols K J K J K J K K, J K J K J K J K, SE0 SE0 J. tx_en high for 19 cycles, then done pulse, busy low.
- Stuff on, BIT_DIV=1, byte 0xFF last -> data symbols K K K K K J J J J (stuff after 5th data bit), then SE0 SE0 J. 20 symbols total.
- Stuff off, same 0xFF -> data K x8, then EOP. 19 symbols, no stuff.
- Two bytes 0xA5 (last=0), 0x3C (last=1), tx_valid held -> tx_ready pulses exactly twice: at acceptance, and at the tick ending the 8th bit of 0xA5. Line continuous, no gap.
- Byte 0x12 last=0, tx_valid dropped after acceptance -> tx_err single pulse at end of byte, then SE0 SE0 J, done pulse.
- BIT_DIV=4: every symbol held 4 cycles. tx_start during SYNC ignored. rst asserted in 3rd SYNC symbol -> next cycle k=0, j=1, tx_en=0, busy=0, no done.
